// File: rtl/mysystem_spi_master_ctrl.sv
// mysystem_spi_master_ctrl
//   Avalon-MM SPI master, mode 0 (sclk idles low, sample on rising edge,
//   shift on falling edge), MSB first, one DATA_W-bit word per transfer.
//   The SCLK half-period is (div+1) clk cycles. The divider is copied into a
//   shadow register when a transfer starts, so CONTROL writes made during a
//   transfer only apply to the next one.
//
// Ports
//   clk, reset_n        system clock, asynchronous active-low reset
//   address[1:0]        0 TXDATA(W) 1 RXDATA(R) 2 STATUS 3 CONTROL
//   write, writedata    single-cycle Avalon write
//   read, readdata      single-cycle Avalon read, data registered (1 cycle)
//   irq                 rx_valid & CONTROL.ie
//   spi_sclk/mosi/ss_n  SPI outputs (sclk idle low, ss_n active low)
//   spi_miso            SPI input
//
// Register map
//   STATUS : bit0 busy, bit1 rx_valid, bit2 overrun (write 1 to clear)
//   CONTROL: [DIV_W-1:0] div, bit31 ie
module mysystem_spi_master_ctrl #(
    parameter int DATA_W      = 8,
    parameter int DIV_W       = 16,
    parameter int DEFAULT_DIV = 4
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [1:0]  address,
    input  logic        write,
    input  logic [31:0] writedata,
    input  logic        read,
    output logic [31:0] readdata,
    output logic        irq,
    output logic        spi_sclk,
    output logic        spi_mosi,
    input  logic        spi_miso,
    output logic        spi_ss_n
);
    localparam int              HP_W    = $clog2(2 * DATA_W);
    localparam logic [HP_W-1:0] HP_LAST = HP_W'(2 * DATA_W - 1);
    localparam logic [HP_W-1:0] HP_PEN  = HP_W'(2 * DATA_W - 2);

    localparam logic [1:0] A_TX     = 2'd0;
    localparam logic [1:0] A_RX     = 2'd1;
    localparam logic [1:0] A_STATUS = 2'd2;
    localparam logic [1:0] A_CTRL   = 2'd3;

    typedef enum logic [1:0] {S_IDLE, S_SETUP, S_SHIFT, S_HOLD} state_t;

    state_t            state_q, state_d;
    logic [DIV_W-1:0]  cnt_q, cnt_d;
    logic [DIV_W-1:0]  shdiv_q, shdiv_d;
    logic [DIV_W-1:0]  div_q, div_d;
    logic [HP_W-1:0]   hp_q, hp_d;
    logic [DATA_W-1:0] tx_q, tx_d;
    logic [DATA_W-1:0] rxsh_q, rxsh_d;
    logic [DATA_W-1:0] rxdata_q, rxdata_d;
    logic              sclk_q, sclk_d;
    logic              ss_n_q, ss_n_d;
    logic              ie_q, ie_d;
    logic              rxv_q, rxv_d;
    logic              ovr_q, ovr_d;
    logic [31:0]       readdata_q, readdata_d;
    logic [31:0]       rd_mux;
    logic              busy, tc, done;
    logic              wr_tx;
    logic              unused_wdata;

    assign unused_wdata = ^writedata;
    assign wr_tx        = write && (address == A_TX);

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        shdiv_d    = shdiv_q;
        div_d      = div_q;
        hp_d       = hp_q;
        tx_d       = tx_q;
        rxsh_d     = rxsh_q;
        rxdata_d   = rxdata_q;
        sclk_d     = sclk_q;
        ss_n_d     = ss_n_q;
        ie_d       = ie_q;
        rxv_d      = rxv_q;
        ovr_d      = ovr_q;
        readdata_d = readdata_q;
        rd_mux     = '0;
        done       = 1'b0;
        busy       = (state_q != S_IDLE);
        tc         = (cnt_q == shdiv_q);

        // Half-period counter runs 0..shdiv whenever a transfer is active.
        if (busy) begin
            cnt_d = tc ? '0 : cnt_q + DIV_W'(1);
        end

        case (state_q)
            S_IDLE: begin
                if (wr_tx) begin
                    state_d = S_SETUP;
                    cnt_d   = '0;
                    shdiv_d = div_q;
                    tx_d    = writedata[DATA_W-1:0];
                    rxsh_d  = '0;
                    ss_n_d  = 1'b0;
                end
            end
            S_SETUP: begin
                // Leaving SETUP is the first rising edge: sample MISO now.
                if (tc) begin
                    state_d = S_SHIFT;
                    hp_d    = '0;
                    sclk_d  = 1'b1;
                    rxsh_d  = {rxsh_q[DATA_W-2:0], spi_miso};
                end
            end
            S_SHIFT: begin
                // hp_q even = sclk high, odd = sclk low.
                if (tc) begin
                    if (hp_q == HP_LAST) begin
                        state_d = S_HOLD;
                    end else begin
                        hp_d = hp_q + HP_W'(1);
                        if (hp_q[0]) begin
                            sclk_d = 1'b1;
                            rxsh_d = {rxsh_q[DATA_W-2:0], spi_miso};
                        end else begin
                            sclk_d = 1'b0;
                            // The final falling edge keeps the last bit on MOSI.
                            if (hp_q != HP_PEN) begin
                                tx_d = tx_q << 1;
                            end
                        end
                    end
                end
            end
            S_HOLD: begin
                if (tc) begin
                    state_d = S_IDLE;
                    ss_n_d  = 1'b1;
                    tx_d    = '0;
                    done    = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (wr_tx && busy) begin
            ovr_d = 1'b1;
        end else if (write && (address == A_STATUS) && writedata[2]) begin
            ovr_d = 1'b0;
        end

        if (write && (address == A_CTRL)) begin
            div_d = writedata[DIV_W-1:0];
            ie_d  = writedata[31];
        end

        case (address)
            A_RX:     rd_mux[DATA_W-1:0] = rxdata_q;
            A_STATUS: rd_mux[2:0]        = {ovr_q, rxv_q, busy};
            A_CTRL: begin
                rd_mux[DIV_W-1:0] = div_q;
                rd_mux[31]        = ie_q;
            end
            default:  rd_mux = '0;
        endcase

        if (read) begin
            readdata_d = rd_mux;
        end

        // Completion overrides a coincident RXDATA read clear.
        if (read && (address == A_RX)) begin
            rxv_d = 1'b0;
        end
        if (done) begin
            rxv_d    = 1'b1;
            rxdata_d = rxsh_q;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            shdiv_q    <= DIV_W'(DEFAULT_DIV);
            div_q      <= DIV_W'(DEFAULT_DIV);
            hp_q       <= '0;
            tx_q       <= '0;
            rxsh_q     <= '0;
            rxdata_q   <= '0;
            sclk_q     <= 1'b0;
            ss_n_q     <= 1'b1;
            ie_q       <= 1'b0;
            rxv_q      <= 1'b0;
            ovr_q      <= 1'b0;
            readdata_q <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            shdiv_q    <= shdiv_d;
            div_q      <= div_d;
            hp_q       <= hp_d;
            tx_q       <= tx_d;
            rxsh_q     <= rxsh_d;
            rxdata_q   <= rxdata_d;
            sclk_q     <= sclk_d;
            ss_n_q     <= ss_n_d;
            ie_q       <= ie_d;
            rxv_q      <= rxv_d;
            ovr_q      <= ovr_d;
            readdata_q <= readdata_d;
        end
    end

    assign readdata = readdata_q;
    assign irq      = rxv_q & ie_q;
    assign spi_sclk = sclk_q;
    assign spi_mosi = tx_q[DATA_W-1];
    assign spi_ss_n = ss_n_q;

endmodule

// File: tb/tb_mysystem_spi_master_ctrl.sv
// Testbench for mysystem_spi_master_ctrl: bus stimulus plus an SPI slave
// model; expectations go into queues and a single negedge monitor compares.
module tb_mysystem_spi_master_ctrl;
    localparam int DATA_W      = 8;
    localparam int DIV_W       = 16;
    localparam int DEFAULT_DIV = 4;
    localparam int CYC_LIMIT   = 40000;
    localparam logic [35:0] PM_ALL = '1;
    localparam logic [35:0] PM_IRQ = 36'h0_0000_0008;

    logic        clk       = 1'b0;
    logic        reset_n   = 1'b1;
    logic [1:0]  address   = '0;
    logic        write     = 1'b0;
    logic [31:0] writedata = '0;
    logic        read      = 1'b0;
    logic [31:0] readdata;
    logic        irq, spi_sclk, spi_mosi, spi_miso, spi_ss_n;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    mysystem_spi_master_ctrl #(
        .DATA_W(DATA_W), .DIV_W(DIV_W), .DEFAULT_DIV(DEFAULT_DIV)
    ) dut (
        .clk(clk), .reset_n(reset_n), .address(address), .write(write),
        .writedata(writedata), .read(read), .readdata(readdata), .irq(irq),
        .spi_sclk(spi_sclk), .spi_mosi(spi_mosi), .spi_miso(spi_miso),
        .spi_ss_n(spi_ss_n)
    );

    // SPI slave: presents word MSB first, next bit after every falling sclk.
    logic [DATA_W-1:0] slave_word = '0;
    int miso_mode = 0;   // 0 slave word, 1 loopback, 2 tied high
    int nfall = 0;
    int sidx;
    always @(negedge spi_sclk or posedge spi_ss_n)
        if (spi_ss_n) nfall = 0;
        else nfall = nfall + 1;
    always_comb begin
        sidx = (nfall < DATA_W) ? (DATA_W - 1 - nfall) : 0;
        case (miso_mode)
            1:       spi_miso = spi_mosi;
            2:       spi_miso = 1'b1;
            default: spi_miso = slave_word[sidx];
        endcase
    end

    // Scoreboard queues.
    typedef struct { logic [DATA_W-1:0] tx; int div; } xfer_t;
    xfer_t       xq[$];
    logic [31:0] rq_val[$];
    string       rq_name[$];
    logic [35:0] pq_val[$];
    logic [35:0] pq_mask[$];
    string       pq_name[$];
    bit          stim_done = 1'b0;

    // Reference model of the register file.
    logic [DATA_W-1:0] m_rx  = '0;
    bit                m_rxv = 1'b0;
    bit                m_ovr = 1'b0;
    bit                m_ie  = 1'b0;
    int                m_div = DEFAULT_DIV;

    function automatic logic [31:0] m_status(input bit busy);
        return {29'b0, m_ovr, m_rxv, busy};
    endfunction
    function automatic logic [31:0] m_ctrl();
        return (m_ie ? 32'h8000_0000 : 32'h0) | 32'(m_div);
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: every comparison happens here, on the falling clock edge.
    logic        rd_cap = 1'b0;
    always @(posedge clk) rd_cap <= read & reset_n;

    int          cyc = 0;
    bit          in_x = 1'b0, prev_sclk = 1'b0;
    int          lowcnt, pulses, hirun, hibad, cur_div;
    logic [31:0] mword;
    xfer_t       xr;
    logic [35:0] pv, pm;
    string       pn;

    always @(negedge clk) begin
        cyc++;
        if (cyc > CYC_LIMIT) begin
            chk("watchdog_cycles", 64'(cyc), 64'(CYC_LIMIT));
            $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
            $finish;
        end
        while (pq_val.size() > 0) begin
            pv = pq_val.pop_front();
            pm = pq_mask.pop_front();
            pn = pq_name.pop_front();
            chk(pn, 64'({readdata, irq, spi_sclk, spi_mosi, spi_ss_n} & pm), 64'(pv & pm));
        end
        if (rd_cap && reset_n) begin
            if (rq_val.size() == 0) begin
                chk("read_unexpected", 64'(rq_val.size()), 64'd1);
            end else begin
                pn = rq_name.pop_front();
                chk(pn, 64'(readdata), 64'(rq_val.pop_front()));
            end
        end
        if (!reset_n) begin
            in_x = 1'b0;
        end else if (spi_ss_n === 1'b0) begin
            if (!in_x) begin
                in_x = 1'b1; lowcnt = 0; pulses = 0; hirun = 0; hibad = 0;
                mword = '0; prev_sclk = 1'b0;
                cur_div = (xq.size() > 0) ? xq[0].div : 0;
            end
            lowcnt++;
            if (spi_sclk) begin
                if (!prev_sclk) begin
                    pulses++;
                    mword = {mword[30:0], spi_mosi};
                end
                hirun++;
            end else if (prev_sclk) begin
                if (hirun != cur_div + 1) hibad++;
                hirun = 0;
            end
            prev_sclk = spi_sclk;
        end else if (in_x) begin
            in_x = 1'b0;
            if (xq.size() == 0) begin
                chk("xfer_unexpected", 64'(xq.size()), 64'd1);
            end else begin
                xr = xq.pop_front();
                chk("xfer_mosi_word", 64'(mword), 64'(xr.tx));
                chk("xfer_sclk_pulses", 64'(pulses), 64'(DATA_W));
                chk("xfer_busy_cycles", 64'(lowcnt), 64'((2 * DATA_W + 2) * (xr.div + 1)));
                chk("xfer_sclk_high_len", 64'(hibad), 64'd0);
            end
        end
        if (stim_done) begin
            chk("read_queue_drained", 64'(rq_val.size()), 64'd0);
            chk("xfer_queue_drained", 64'(xq.size()), 64'd0);
            $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
            $finish;
        end
    end

    task automatic pin(input string name, input logic [35:0] exp, input logic [35:0] mask);
        pq_val.push_back(exp); pq_mask.push_back(mask); pq_name.push_back(name);
    endtask

    task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
        @(posedge clk); #1;
        address = a; writedata = d; write = 1'b1;
        @(posedge clk); #1;
        write = 1'b0;
    endtask

    task automatic bus_read(input logic [1:0] a, input logic [31:0] exp, input string name);
        @(posedge clk); #1;
        address = a; read = 1'b1;
        rq_val.push_back(exp); rq_name.push_back(name);
        @(posedge clk); #1;
        read = 1'b0;
    endtask

    task automatic set_ctrl(input int div, input bit ie);
        bus_write(2'd3, (ie ? 32'h8000_0000 : 32'h0) | 32'(div));
        m_div = div; m_ie = ie;
    endtask

    task automatic rd_rx(input string name);
        bus_read(2'd1, 32'(m_rx), name);
        m_rxv = 1'b0;
    endtask

    task automatic start_xfer(input logic [DATA_W-1:0] tx, input logic [DATA_W-1:0] sw,
                              input int mode, output int n, output logic [DATA_W-1:0] e);
        @(posedge clk); #1;
        slave_word = sw; miso_mode = mode;
        address = 2'd0; writedata = 32'(tx); write = 1'b1;
        @(posedge clk); #1;
        write = 1'b0;
        xq.push_back('{tx, m_div});
        n = (2 * DATA_W + 2) * (m_div + 1);
        e = (mode == 1) ? tx : (mode == 2) ? '1 : sw;
    endtask

    task automatic finish_xfer(input int n, input logic [DATA_W-1:0] e);
        repeat (n + 1) @(posedge clk);
        m_rx = e; m_rxv = 1'b1;
    endtask

    initial begin
        int n, n2;
        logic [DATA_W-1:0] e, e2;

        #2 reset_n = 1'b0;
        repeat (3) @(posedge clk); #1;
        pin("reset_pins", 36'h0_0000_0001, PM_ALL);
        repeat (2) @(posedge clk); #1;
        reset_n = 1'b1;
        bus_read(2'd2, m_status(0), "status_reset");
        bus_read(2'd3, m_ctrl(), "ctrl_reset");
        bus_read(2'd1, 32'(m_rx), "rxdata_reset");

        // div=0 loopback 0xA5
        set_ctrl(0, 0);
        start_xfer(8'hA5, 8'h00, 1, n, e);
        finish_xfer(n, e);
        pin("irq_off_when_ie0", 36'h0, PM_IRQ);
        bus_read(2'd2, m_status(0), "status_loopback_done");
        rd_rx("rxdata_loopback");
        bus_read(2'd2, m_status(0), "status_after_rxread");

        // div=3, 0x3C, miso tied high
        set_ctrl(3, 0);
        start_xfer(8'h3C, 8'h00, 2, n, e);
        finish_xfer(n, e);
        rd_rx("rxdata_tied_high");

        // overrun during busy, W1C semantics
        set_ctrl(1, 0);
        start_xfer(8'h5A, 8'($urandom), 0, n, e);
        repeat (5) @(posedge clk);
        bus_write(2'd0, 32'h11);
        m_ovr = 1'b1;
        bus_read(2'd2, m_status(1), "status_busy_overrun");
        finish_xfer(n, e);
        bus_read(2'd2, m_status(0), "status_overrun_done");
        rd_rx("rxdata_overrun_xfer");
        bus_write(2'd2, 32'h3);
        bus_read(2'd2, m_status(0), "status_w1c_bit2_clear_kept");
        bus_write(2'd2, 32'h4);
        m_ovr = 1'b0;
        bus_read(2'd2, m_status(0), "status_overrun_cleared");

        // irq with ie=1
        set_ctrl(0, 1);
        start_xfer(8'($urandom), 8'($urandom), 0, n, e);
        finish_xfer(n, e);
        pin("irq_set", 36'h8, PM_IRQ);
        rd_rx("rxdata_irq");
        pin("irq_clear_after_read", 36'h0, PM_IRQ);

        // RXDATA read coincident with completion: old data, rx_valid kept
        start_xfer(8'($urandom), 8'($urandom), 0, n, e);
        repeat (n - 2) @(posedge clk);
        bus_read(2'd1, 32'(m_rx), "rxdata_coincident_old");
        m_rx = e; m_rxv = 1'b1;
        pin("irq_coincident", 36'h8, PM_IRQ);
        bus_read(2'd2, m_status(0), "status_coincident_valid");
        rd_rx("rxdata_coincident_new");
        bus_read(2'd2, m_status(0), "status_coincident_cleared");

        // reset mid-SHIFT
        set_ctrl(2, 1);
        start_xfer(8'($urandom), 8'($urandom), 0, n, e);
        repeat (10) @(posedge clk); #1;
        reset_n = 1'b0;
        xq.delete();
        m_rx = '0; m_rxv = 1'b0; m_ovr = 1'b0; m_ie = 1'b0; m_div = DEFAULT_DIV;
        pin("abort_pins", 36'h0_0000_0001, PM_ALL);
        repeat (2) @(posedge clk); #1;
        reset_n = 1'b1;
        bus_read(2'd2, m_status(0), "status_after_abort");
        bus_read(2'd3, m_ctrl(), "ctrl_after_abort");
        start_xfer(8'($urandom), 8'($urandom), 0, n, e);
        finish_xfer(n, e);
        rd_rx("rxdata_after_abort");

        // CONTROL write during busy affects only the next transfer
        set_ctrl(1, 0);
        start_xfer(8'($urandom), 8'($urandom), 0, n, e);
        repeat (6) @(posedge clk);
        set_ctrl(7, 0);
        finish_xfer(n, e);
        bus_read(2'd3, m_ctrl(), "ctrl_div7");
        rd_rx("rxdata_old_div");
        start_xfer(8'($urandom), 8'($urandom), 0, n, e);
        finish_xfer(n, e);
        rd_rx("rxdata_div7");

        // back-to-back: second write lands on the first idle cycle
        for (int i = 0; i < 3; i++) begin
            set_ctrl(int'($urandom_range(0, 3)), 0);
            start_xfer(8'($urandom), 8'($urandom), 0, n, e);
            repeat (n - 1) @(posedge clk);
            start_xfer(8'($urandom), 8'($urandom), 0, n2, e2);
            finish_xfer(n2, e2);
            bus_read(2'd2, m_status(0), "status_b2b");
            rd_rx("rxdata_b2b");
        end

        // random single transfers, random MISO source
        for (int i = 0; i < 4; i++) begin
            set_ctrl(int'($urandom_range(0, 2)), 1'($urandom));
            start_xfer(8'($urandom), 8'($urandom), int'($urandom_range(0, 2)), n, e);
            finish_xfer(n, e);
            bus_read(2'd2, m_status(0), "status_rand");
            rd_rx("rxdata_rand");
        end

        repeat (5) @(posedge clk);
        stim_done = 1'b1;
    end

endmodule
